// File: rtl/bit_serial_adder.sv
// Purpose : multi-cycle adder that drives one full-adder slice per clock, LSB first,
//           holding the carry in a flop and shifting sum bits into a result register.
// Latency : WIDTH cycles from accepted start to the done pulse; new op every WIDTH+1 cycles.
// Backpressure: none; start is accepted in IDLE or DONE and silently ignored while busy.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, a, b, cin  operation request and operands, captured on an accepted start
//   sub               (only with SERIAL_ADD_SUB_EN) 1 = compute a-b, cout=1 means no borrow
//   busy, done        busy while bits are processed; done pulses one cycle with the result
//   sum, cout         result, held until the first RUN edge of the next operation
//
// Optional feature macro: SERIAL_ADD_SUB_EN adds the sub input (subtract mode).
module bit_serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // Operand values as they would be loaded on an accepted start.
    logic [WIDTH-1:0] b_load;
    logic             carry_load;

`ifdef SERIAL_ADD_SUB_EN
    // Two's complement subtract: a + ~b + 1, so cin is overridden.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    // The single full-adder slice.
    logic fa_s, fa_c;
    assign fa_s = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign fa_c = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands in sum[0].
                sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    cout_d  = fa_c;
                    state_d = DONE;
                    // Return to 0 rather than incrementing so the counter never
                    // leaves 0..WIDTH-1 for non-power-of-two widths.
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_sr_d  = a;
                    b_sr_d  = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    // Decoded straight from the state flop so reset clears them immediately.
    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
module tb_bit_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    bit_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge-aligned point; returns at the negedge where done is seen.
    task automatic wait_done(output int busy_cnt, output bit seen, output int done_cyc);
        busy_cnt = 0;
        seen     = 1'b0;
        done_cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                seen     = 1'b1;
                done_cyc = cyc;
                break;
            end
            if (busy) busy_cnt++;
        end
    endtask

    task automatic count_dones(input int ncyc, output int ndone);
        ndone = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
    endtask

    // Called just after a posedge. Runs one operation and checks it completely.
    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input logic sb,
                          input logic [7:0] exp_sum, input logic exp_cout);
        int  bc;
        bit  seen;
        int  dc;
        a     = av;
        b     = bv;
        cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
        sub   = sb;
`else
        if (sb) $display("note: sub requested without subtract support");
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        cin   = 1'b0;
        wait_done(bc, seen, dc);
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        @(negedge clk);
        check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
        check({tag, "_sum_held"}, 32'(sum), 32'(exp_sum));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  bc;
        bit  seen;
        int  c1;
        int  c2;
        int  nd;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub   = 1'b0;
`endif
        #12;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic additions and wrap-around.
        run_op("add_35_4a", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);
        run_op("add_5a_a5_c", 8'h5A, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b1);

        // Start while busy is ignored.
        a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ignore_busy_still", 32'(busy), 32'd1);
        wait_done(bc, seen, c1);
        check("ignore_done_seen", 32'(seen), 32'd1);
        check("ignore_sum", 32'(sum), 32'h03);
        check("ignore_cout", 32'(cout), 32'd0);
        count_dones(14, nd);
        check("ignore_single_done", 32'(nd), 32'd0);
        @(posedge clk);
        #1;

        // Start held high: back-to-back results.
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        a = 8'h0F; b = 8'h01;
        wait_done(bc, seen, c1);
        check("b2b_first_seen", 32'(seen), 32'd1);
        check("b2b_first_sum", 32'(sum), 32'h30);
        check("b2b_first_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_reaccept_busy", 32'(busy), 32'd1);
        wait_done(bc, seen, c2);
        check("b2b_second_seen", 32'(seen), 32'd1);
        check("b2b_second_sum", 32'(sum), 32'h10);
        check("b2b_gap", 32'(c2 - c1), 32'd9);
        @(posedge clk);
        #1;

        // Reset in the middle of an operation.
        a = 8'h35; b = 8'h4A; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum",  32'(sum),  32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        count_dones(12, nd);
        check("midrst_no_done", 32'(nd), 32'd0);
        @(posedge clk);
        #1;
        run_op("after_rst", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        run_op("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
        run_op("sub0_add", 8'h35, 8'h4A, 1'b0, 1'b0, 8'h7F, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
